fifo_rd_prefetch: RTL and testbench



---
 rtl/fifo_rd_prefetch.sv | 107 ++++++++++
 tb/tb_fifo_rd_prefetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_prefetch.sv
// fifo_rd_prefetch: read-side prefetch stage behind the async FIFO controller.
// Pops ahead of the consumer and absorbs the RAM read latency in a skid buffer.
module fifo_rd_prefetch #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst_n,
    input  logic                  i_empty,
    output logic                  o_pop,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [1:0]            o_level
);

    localparam int SKID_DEPTH = RD_LAT + 1;
    localparam int PW         = $clog2(SKID_DEPTH);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("fifo_rd_prefetch: RD_LAT must be 1 or 2");
    end

    logic                  run_q;
    logic [RD_LAT-1:0]     pipe_q;
    logic [RD_LAT-1:0]     pipe_d;
    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         head_d;
    logic [PW-1:0]         tail_q;
    logic [PW-1:0]         tail_d;
    logic [1:0]            level_q;
    logic [1:0]            level_d;
    logic [2:0]            inflight;
    logic [2:0]            credits;
    logic                  drain;
    logic                  cap;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Count pops still waiting for their RAM word.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, pipe_q[i]};
        end
    end

    assign drain   = o_valid & i_ready;
    assign cap     = pipe_q[RD_LAT-1];
    assign credits = {1'b0, level_q} + inflight;
    assign o_pop   = run_q & ~i_empty
                   & ((credits - {2'b00, drain}) < 3'(SKID_DEPTH));

    assign o_valid = (level_q != 2'd0);
    assign o_level = level_q;
    assign o_data  = mem_q[head_q];

    // Next-state for the pop delay line, pointers and fill level.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = o_pop;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        head_d  = drain ? ptr_inc(head_q) : head_q;
        tail_d  = cap ? ptr_inc(tail_q) : tail_q;
        level_d = level_q;
        if (cap && !drain) begin
            level_d = level_q + 2'd1;
        end else if (!cap && drain) begin
            level_d = level_q - 2'd1;
        end
    end

    // Control state: run flag arms one edge after reset release.
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            run_q   <= 1'b0;
            pipe_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= 2'd0;
        end else begin
            run_q   <= 1'b1;
            pipe_q  <= pipe_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Skid storage: returned RAM word lands at the tail.
    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cap) begin
            mem_q[tail_q] <= i_rdata;
        end
    end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// tb_fifo_rd_prefetch: directed bench for the read prefetch stage.
// Drives an RD_LAT=1 and an RD_LAT=2 instance side by side.
module tb_fifo_rd_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       e1, pop1, v1, r1;
    logic [7:0] rd1, d1;
    logic [1:0] l1;
    logic       e2, pop2, v2, r2;
    logic [7:0] rd2, d2, s2;
    logic [1:0] l2;
    logic [7:0] base;
    logic [7:0] cnt1, cnt2;
    int         total = 0;
    int         bad = 0;

    fifo_rd_prefetch #(.DATA_WIDTH(8), .RD_LAT(1)) dut1 (
        .i_rclk(clk), .i_rrst_n(rst_n), .i_empty(e1), .o_pop(pop1),
        .i_rdata(rd1), .o_data(d1), .o_valid(v1), .i_ready(r1),
        .o_level(l1)
    );

    fifo_rd_prefetch #(.DATA_WIDTH(8), .RD_LAT(2)) dut2 (
        .i_rclk(clk), .i_rrst_n(rst_n), .i_empty(e2), .o_pop(pop2),
        .i_rdata(rd2), .o_data(d2), .o_valid(v2), .i_ready(r2),
        .o_level(l2)
    );

    // RAM model, latency 1: word = 0x10 + base + pop index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 8'd0;
        end else if (pop1) begin
            rd1  <= 8'h10 + base + cnt1;
            cnt1 <= cnt1 + 8'd1;
        end
    end

    // RAM model, latency 2: word = base + pop index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt2 <= 8'd0;
        end else begin
            rd2 <= s2;
            if (pop2) begin
                s2   <= base + cnt2;
                cnt2 <= cnt2 + 8'd1;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        e1 = 1'b1; e2 = 1'b1; r1 = 1'b0; r2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        e1 = 1'b0; e2 = 1'b0; r1 = 1'b1; r2 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (pop1 !== 1'b0 || pop2 !== 1'b0) begin
                bad++;
                $display("FAIL rst_pop got=%0b%0b exp=00", pop1, pop2);
            end
            total++;
            if (v1 !== 1'b0 || l1 !== 2'd0 || d1 !== 8'd0) begin
                bad++;
                $display("FAIL rst_out1 got v=%0b l=%0d d=%h exp 0/0/00",
                         v1, l1, d1);
            end
            total++;
            if (v2 !== 1'b0 || l2 !== 2'd0 || d2 !== 8'd0) begin
                bad++;
                $display("FAIL rst_out2 got v=%0b l=%0d d=%h exp 0/0/00",
                         v2, l2, d2);
            end
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (pop1 !== 1'b0 || pop2 !== 1'b0) begin
            bad++;
            $display("FAIL rel_pop got=%0b%0b exp=00", pop1, pop2);
        end
        @(posedge clk);
        #1;
        total++;
        if (pop1 !== 1'b1 || pop2 !== 1'b1) begin
            bad++;
            $display("FAIL run_pop got=%0b%0b exp=11", pop1, pop2);
        end
    endtask

    task automatic test_stream();
        do_reset();
        e1 = 1'b0; r1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (pop1 !== 1'b1) begin
                bad++;
                $display("FAIL stream_pop c%0d got=%0b exp=1", k, pop1);
            end
            total++;
            if (v1 !== (k >= 3)) begin
                bad++;
                $display("FAIL stream_valid c%0d got=%0b exp=%0b",
                         k, v1, (k >= 3));
            end
            total++;
            if (l1 !== ((k >= 3) ? 2'd1 : 2'd0)) begin
                bad++;
                $display("FAIL stream_level c%0d got=%0d", k, l1);
            end
            if (k >= 3) begin
                total++;
                if (d1 !== 8'h10 + 8'(k - 3)) begin
                    bad++;
                    $display("FAIL stream_data c%0d got=%h exp=%h",
                             k, d1, 8'h10 + 8'(k - 3));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int npop = 0;
        do_reset();
        e1 = 1'b0; r1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (pop1) npop++;
        end
        total++;
        if (npop != 2) begin
            bad++;
            $display("FAIL bp_npop got=%0d exp=2", npop);
        end
        total++;
        if (l1 !== 2'd2 || v1 !== 1'b1 || d1 !== 8'h10 || pop1 !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold got l=%0d v=%0b d=%h pop=%0b exp 2/1/10/0",
                     l1, v1, d1, pop1);
        end
        @(posedge clk);
        #1;
        r1 = 1'b1;
        #1;
        total++;
        if (pop1 !== 1'b1 || d1 !== 8'h10) begin
            bad++;
            $display("FAIL bp_resume got pop=%0b d=%h exp 1/10", pop1, d1);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (d1 !== 8'h11 || l1 !== 2'd1) begin
            bad++;
            $display("FAIL bp_drain1 got d=%h l=%0d exp 11/1", d1, l1);
        end
        @(negedge clk);
        total++;
        if (d1 !== 8'h12 || l1 !== 2'd1 || v1 !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain2 got d=%h l=%0d v=%0b exp 12/1/1",
                     d1, l1, v1);
        end
        e1 = 1'b1; r1 = 1'b0;
    endtask

    task automatic test_toggle();
        int npop = 0;
        int nrx = 0;
        int dl;
        logic [1:0] prev_l = 2'd0;
        logic prev_drain = 1'b0;
        do_reset();
        e2 = 1'b0;
        for (int cyc = 0; cyc < 200 && nrx < 20; cyc++) begin
            @(posedge clk);
            #1;
            if (npop >= 20) e2 = 1'b1;
            r2 = (cyc % 2 == 0);
            @(negedge clk);
            dl = int'(l2) - int'(prev_l);
            total++;
            if (dl > 1 || dl < -1 || (dl == -1 && !prev_drain)) begin
                bad++;
                $display("FAIL tog_level c%0d got=%0d prev=%0d", cyc, l2,
                         prev_l);
            end
            total++;
            if (v2 !== (l2 != 2'd0)) begin
                bad++;
                $display("FAIL tog_valid c%0d got=%0b lvl=%0d", cyc, v2, l2);
            end
            if (pop2) npop++;
            if (v2 && r2) begin
                total++;
                if (d2 !== 8'(nrx)) begin
                    bad++;
                    $display("FAIL tog_data #%0d got=%h exp=%h", nrx, d2,
                             8'(nrx));
                end
                nrx++;
            end
            prev_l = l2;
            prev_drain = v2 & r2;
        end
        total++;
        if (nrx != 20 || npop != 20) begin
            bad++;
            $display("FAIL tog_count got rx=%0d pop=%0d exp 20/20", nrx, npop);
        end
        @(posedge clk);
        #1;
        e2 = 1'b1; r2 = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (v2 !== 1'b0 || l2 !== 2'd0) begin
            bad++;
            $display("FAIL tog_extra got v=%0b l=%0d exp 0/0", v2, l2);
        end
        r2 = 1'b0;
    endtask

    task automatic test_single();
        int n1 = 0;
        int n2 = 0;
        do_reset();
        r1 = 1'b1; r2 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            e1 = (k != 2); e2 = (k != 2);
            @(negedge clk);
            if (pop1) n1++;
            if (pop2) n2++;
            total++;
            if (v1 !== (k == 4) || (k == 4 && d1 !== 8'h10)) begin
                bad++;
                $display("FAIL single1 c%0d got v=%0b d=%h exp v=%0b d=10",
                         k, v1, d1, (k == 4));
            end
            total++;
            if (v2 !== (k == 5) || (k == 5 && d2 !== 8'h00)) begin
                bad++;
                $display("FAIL single2 c%0d got v=%0b d=%h exp v=%0b d=00",
                         k, v2, d2, (k == 5));
            end
        end
        total++;
        if (n1 != 1 || n2 != 1 || l1 !== 2'd0 || l2 !== 2'd0) begin
            bad++;
            $display("FAIL single_end got n=%0d/%0d l=%0d/%0d exp 1/1 0/0",
                     n1, n2, l1, l2);
        end
    endtask

    task automatic test_reset_mid();
        int nrx = 0;
        do_reset();
        e2 = 1'b0; r2 = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (l2 !== 2'd2 || v2 !== 1'b1 || d2 !== 8'h00) begin
            bad++;
            $display("FAIL mid_pre got l=%0d v=%0b d=%h exp 2/1/00",
                     l2, v2, d2);
        end
        #2;
        rst_n = 1'b0;
        base = 8'h40;
        #1;
        total++;
        if (v2 !== 1'b0 || l2 !== 2'd0 || pop2 !== 1'b0 || d2 !== 8'h00) begin
            bad++;
            $display("FAIL mid_async got v=%0b l=%0d pop=%0b d=%h exp 0/0/0/00",
                     v2, l2, pop2, d2);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (pop2 !== 1'b0) begin
            bad++;
            $display("FAIL mid_rel_pop got=%0b exp=0", pop2);
        end
        r2 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (pop2 !== 1'b1) begin
            bad++;
            $display("FAIL mid_run_pop got=%0b exp=1", pop2);
        end
        for (int k = 0; k < 12 && nrx < 3; k++) begin
            @(negedge clk);
            if (v2 && r2) begin
                total++;
                if (d2 !== 8'h40 + 8'(nrx)) begin
                    bad++;
                    $display("FAIL mid_data #%0d got=%h exp=%h", nrx, d2,
                             8'h40 + 8'(nrx));
                end
                nrx++;
            end
        end
        total++;
        if (nrx != 3) begin
            bad++;
            $display("FAIL mid_count got=%0d exp=3", nrx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        base = 8'h00;
        e1 = 1'b1; e2 = 1'b1; r1 = 1'b0; r2 = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_single();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
